// File: rtl/add_arb_pkg.sv
// Shared types and defaults for the two-requester adder arbiter.
package add_arb_pkg;

    localparam int DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/add_core.sv
// Combinational DW-bit adder with the carry-out as bit DW of the result.
// Zero latency; no flow control of its own.
module add_core #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW:0]   o_sum
);

    assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/add_arbiter.sv
// Shares one adder between two requesters: grant -> EXEC -> RESP, rsp_valid two cycles after the grant.
// The response is held until rsp_ready; req_ready stays low while busy. ADD_ARB_SAT_EN saturates on carry.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] b0,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] b1,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_carry,
    output logic          busy
);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_last_grant;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic          r_op_id;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_carry;
    logic          r_rsp_id;

    logic          w_any;
    logic          w_grant;
    logic          w_accept;
    logic [DW:0]   w_sum;
    logic [DW-1:0] w_result;

    assign w_any    = |req_valid;
    assign w_accept = (r_state == IDLE) && w_any;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        w_grant = 1'b0;
        case (req_valid)
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~r_last_grant;
            default: w_grant = 1'b0;
        endcase
    end

    add_core #(.DW(DW)) u_add_core (
        .i_a   (r_op_a),
        .i_b   (r_op_b),
        .o_sum (w_sum)
    );

`ifdef ADD_ARB_SAT_EN
    assign w_result = w_sum[DW] ? {DW{1'b1}} : w_sum[DW-1:0];
`else
    assign w_result = w_sum[DW-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next_state = EXEC;
            EXEC:    w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // req_ready is gated by rst_n so held requests see no grant while reset is asserted.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = (r_state == RESP);
        busy      = (r_state != IDLE);
        if ((r_state == IDLE) && w_any && rst_n) begin
            req_ready = w_grant ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_id      <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_id     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_a       <= w_grant ? a1 : a0;
                r_op_b       <= w_grant ? b1 : b0;
                r_op_id      <= w_grant;
                r_last_grant <= w_grant;
            end
            if (r_state == EXEC) begin
                r_rsp_data  <= w_result;
                r_rsp_carry <= w_sum[DW];
                r_rsp_id    <= r_op_id;
            end
        end
    end

    assign rsp_data  = r_rsp_data;
    assign rsp_carry = r_rsp_carry;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: single op, overflow, contention, backpressure, reset mid-op.
module tb_add_arbiter;

    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [DW-1:0] a0, b0, a1, b1;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW-1:0] rsp_data;
    logic          rsp_carry;
    logic          busy;

    int checks = 0;
    int errors = 0;

`ifdef ADD_ARB_SAT_EN
    localparam logic [DW-1:0] OVF_DATA = 16'hFFFF;
`else
    localparam logic [DW-1:0] OVF_DATA = 16'h0000;
`endif

    add_arbiter #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land on the falling edge, where outputs are sampled and inputs driven.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        @(negedge clk);
        check("rst_busy",      busy,      0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data",  rsp_data,  0);
        check("rst_rsp_carry", rsp_carry, 0);
        check("rst_rsp_id",    rsp_id,    0);
        check("rst_req_ready", req_ready, 0);
        step();
        rst_n = 1'b1;
        step();

        // Single request from requester 0.
        req_valid = 2'b01; a0 = 16'h1234; b0 = 16'h0001; rsp_ready = 1'b1;
        #1;
        check("single_req_ready_N", req_ready, 2'b01);
        check("single_busy_N",      busy,      0);
        step();
        req_valid = 2'b00;
        check("single_req_ready_N1", req_ready, 2'b00);
        check("single_busy_N1",      busy,      1);
        check("single_rsp_valid_N1", rsp_valid, 0);
        step();
        check("single_rsp_valid_N2", rsp_valid, 1);
        check("single_rsp_data",     rsp_data,  16'h1235);
        check("single_rsp_carry",    rsp_carry, 0);
        check("single_rsp_id",       rsp_id,    0);
        step();
        check("single_idle_busy",      busy,      0);
        check("single_idle_rsp_valid", rsp_valid, 0);

        // Overflow on requester 1.
        req_valid = 2'b10; a1 = 16'hFFFF; b1 = 16'h0001;
        #1;
        check("ovf_req_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        step();
        check("ovf_rsp_valid", rsp_valid, 1);
        check("ovf_rsp_data",  rsp_data,  OVF_DATA);
        check("ovf_rsp_carry", rsp_carry, 1);
        check("ovf_rsp_id",    rsp_id,    1);
        step();

        // Both requesters held: last grant was 1, so grants alternate 0,1,0,1.
        req_valid = 2'b11;
        a0 = 16'h0001; b0 = 16'h0002; a1 = 16'h0010; b1 = 16'h0020;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cont%0d_req_ready", i), req_ready, (i % 2) ? 2'b10 : 2'b01);
            step();
            check($sformatf("cont%0d_exec_ready", i), req_ready, 2'b00);
            step();
            check($sformatf("cont%0d_rsp_valid", i), rsp_valid, 1);
            check($sformatf("cont%0d_rsp_id", i),    rsp_id,    i % 2);
            check($sformatf("cont%0d_rsp_data", i),  rsp_data,  (i % 2) ? 16'h0030 : 16'h0003);
            step();
        end
        req_valid = 2'b00;
        step();

        // Backpressure: response held five cycles with requester 0 still requesting.
        req_valid = 2'b01; a0 = 16'h0100; b0 = 16'h0023; rsp_ready = 1'b0;
        #1;
        check("bp_req_ready", req_ready, 2'b01);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_rsp_valid", i), rsp_valid, 1);
            check($sformatf("bp%0d_rsp_data", i),  rsp_data,  16'h0123);
            check($sformatf("bp%0d_rsp_id", i),    rsp_id,    0);
            check($sformatf("bp%0d_req_ready", i), req_ready, 2'b00);
            check($sformatf("bp%0d_busy", i),      busy,      1);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("bp_release_busy",      busy,      0);
        check("bp_release_req_ready", req_ready, 2'b01);
        // Requester withdraws before its handshake; rsp_ready stays high while idle.
        req_valid = 2'b00;
        step();
        check("drop_busy",      busy,      0);
        check("drop_rsp_valid", rsp_valid, 0);

        // Reset during EXEC discards the operation and restores the tie pointer.
        req_valid = 2'b01; a0 = 16'h0005; b0 = 16'h0006;
        #1;
        check("mid_req_ready", req_ready, 2'b01);
        step();
        check("mid_in_exec", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",      busy,      0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_data",  rsp_data,  0);
        check("mid_rst_rsp_carry", rsp_carry, 0);
        check("mid_rst_rsp_id",    rsp_id,    0);
        check("mid_rst_req_ready", req_ready, 0);
        step();
        req_valid = 2'b00;
        rst_n     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mid_post%0d_rsp_valid", i), rsp_valid, 0);
        end
        req_valid = 2'b11; a1 = 16'h0700; b1 = 16'h0080;
        #1;
        check("mid_tie_req_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        step();
        check("mid_tie_rsp_valid", rsp_valid, 1);
        check("mid_tie_rsp_id",    rsp_id,    0);
        check("mid_tie_rsp_data",  rsp_data,  16'h000B);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter DW, default 16: operand and result width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester operation request, bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; one-hot or zero.
REQ-006 a0, b0  input  DW each  requester 0 operands.
REQ-007 a1, b1  input  DW each  requester 1 operands.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_id  output  1  requester that owns the result.
REQ-011 rsp_data  output  DW  sum, low DW bits (or saturated, see Configuration).
REQ-012 rsp_carry  output  1  carry-out of the DW-bit add.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The block SHALL share one DW-bit adder between two requesters using an FSM with states IDLE, EXEC and RESP.
REQ-015 IDLE: if any req_valid bit is set, the block SHALL assert req_ready for exactly one granted requester in the same cycle (combinational from req_valid and pointer), and deassert it otherwise.
REQ-016 Arbitration: one requester valid -> grant it; both valid -> grant the requester not equal to last_grant.
REQ-017 On req_valid[g] & req_ready[g] the block SHALL capture that requester's operands and g, update last_grant to g, and move to EXEC.
REQ-018 EXEC: one cycle; the adder SHALL compute the DW+1-bit sum of the captured operands; rsp_data, rsp_carry and rsp_id SHALL be registered; next state RESP.
REQ-019 RESP: rsp_valid SHALL be 1; rsp_data, rsp_carry and rsp_id SHALL stay stable until rsp_ready is 1; then next state IDLE.
REQ-020 Latency: handshake in cycle N -> rsp_valid high in cycle N+2; earliest next grant is the cycle after the rsp handshake (min 3 cycles per op).
REQ-021 req_ready SHALL be 0 in EXEC and RESP; requests held during those states wait.
REQ-022 A requester may drop req_valid before its handshake; the block takes no action for it.
REQ-023 Wrap-around: rsp_data = (a+b) mod 2^DW, rsp_carry = bit DW of the sum.
REQ-024 rsp_ready asserted while rsp_valid is 0 SHALL be ignored.

Reset
REQ-025 On rst_n low, asynchronously: state IDLE, rsp_valid 0, rsp_data 0, rsp_carry 0, rsp_id 0, last_grant 1 (requester 0 wins first tie), busy 0, req_ready 0.
REQ-026 Reset in EXEC or RESP SHALL discard the operation with no response issued.

Configuration
REQ-027 With macro ADD_ARB_SAT_EN defined: when carry is 1, rsp_data SHALL be all ones; rsp_carry still reports 1.
REQ-028 Without ADD_ARB_SAT_EN: rsp_data is the wrapped sum per REQ-023; no saturation logic is compiled.

Structure
REQ-029 Package add_arb_pkg SHALL hold the state enum (IDLE, EXEC, RESP) and the DW default constant.
REQ-030 The adder SHALL be a sub-module add_core (combinational, DW in, DW+1 out), instantiated once.

Verification
REQ-031 Single request: req_valid=01, a0=0x1234, b0=0x0001, rsp_ready=1 -> rsp_valid at N+2, rsp_data=0x1235, carry 0, rsp_id 0.
REQ-032 Overflow: a1=0xFFFF, b1=0x0001 -> rsp_data=0x0000, carry 1 (0xFFFF, carry 1 with ADD_ARB_SAT_EN).
REQ-033 Contention: req_valid=11 held for four operations -> grants 0,1,0,1; rsp_id matches each grant.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable, req_ready=00, busy 1 throughout.
REQ-035 Reset mid-op: rst_n low during EXEC -> all outputs zero immediately, no rsp_valid after release, next tie grants requester 0.
